// File: rtl/pc_src_pkg.sv
// Shared types and default constants for the PC source controller.
package pc_src_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DEPTH  = 8;
    localparam logic [DEF_ADDR_W-1:0] DEF_INTR_VEC = 10'h3FF;

    typedef enum logic {
        RUN = 1'b0,
        ISR = 1'b1
    } pc_state_t;

    typedef logic [DEF_ADDR_W-1:0] addr_t;

endpackage

// File: rtl/ras_lifo.sv
// Return-address LIFO: pushes while full and pops while empty are ignored here;
// the parent never requests push and pop in the same cycle.
module ras_lifo
    import pc_src_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int W     = DEF_ADDR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   sp_r;
    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_idx_s;
    logic [AW-1:0] rd_idx_s;

    // The low bits of SP wrap to 0 when full, so SP-1 still addresses the last entry.
    assign wr_idx_s = sp_r[AW-1:0];
    assign rd_idx_s = wr_idx_s - AW'(1);
    assign full     = (sp_r == (AW+1)'(DEPTH));
    assign empty    = (sp_r == '0);
    assign top      = empty ? '0 : mem_r[rd_idx_s];

    // Stack pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_r <= '0;
        end else if (push && !full) begin
            sp_r <= sp_r + (AW+1)'(1);
        end else if (pop && !empty) begin
            sp_r <= sp_r - (AW+1)'(1);
        end else begin
            sp_r <= sp_r;
        end
    end

    // Entry storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_r[wr_idx_s] <= din;
        end
    end

endmodule

// File: rtl/pc_src_ctrl.sv
// PC source selection, return-address stack and interrupt state machine.
// Optional build macro PC_SRC_INTR_LATCH_EN latches interrupt requests that arrive while masked.
module pc_src_ctrl
    import pc_src_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter logic [ADDR_W-1:0] INTR_VEC = ADDR_W'(DEF_INTR_VEC)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] PC_COUNT,
    input  logic              ADV,
    input  logic              BR,
    input  logic              CALL,
    input  logic              RET,
    input  logic              RETI,
    input  logic              SEI,
    input  logic              CLI,
    input  logic [ADDR_W-1:0] TGT,
    input  logic              INTR,
    output logic [ADDR_W-1:0] DIN,
    output logic              PC_LD,
    output logic              PC_INC,
    output logic              IN_ISR,
    output logic              IE,
    output logic              OVF,
    output logic              UNF
);

    pc_state_t         state_r;
    pc_state_t         state_nxt_s;
    logic              ie_r;
    logic              ie_nxt_s;
    logic              ovf_r;
    logic              unf_r;
    logic              intr_req_s;
    logic              intr_take_s;
    logic              reti_isr_s;
    logic              push_req_s;
    logic              pop_req_s;
    logic [ADDR_W-1:0] push_data_s;
    logic [ADDR_W-1:0] din_s;
    logic              ld_s;
    logic              inc_s;
    logic [ADDR_W-1:0] top_s;
    logic              full_s;
    logic              empty_s;

`ifdef PC_SRC_INTR_LATCH_EN
    logic pending_r;

    // Remember any request that was not taken so it fires once interrupts open up.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pending_r <= 1'b0;
        end else if (intr_take_s) begin
            pending_r <= 1'b0;
        end else begin
            pending_r <= pending_r | INTR;
        end
    end

    assign intr_req_s = INTR | pending_r;
`else
    assign intr_req_s = INTR;
`endif

    assign intr_take_s = intr_req_s & ie_r & (state_r == RUN);

    // Flow request arbitration; only the highest-priority request acts.
    always_comb begin
        din_s       = '0;
        ld_s        = 1'b0;
        inc_s       = 1'b0;
        push_req_s  = 1'b0;
        pop_req_s   = 1'b0;
        push_data_s = '0;
        reti_isr_s  = 1'b0;
        if (intr_take_s) begin
            din_s       = INTR_VEC;
            ld_s        = 1'b1;
            push_req_s  = 1'b1;
            push_data_s = PC_COUNT;
        end else if (RETI) begin
            din_s      = top_s;
            ld_s       = 1'b1;
            pop_req_s  = 1'b1;
            reti_isr_s = (state_r == ISR);
        end else if (RET) begin
            din_s     = top_s;
            ld_s      = 1'b1;
            pop_req_s = 1'b1;
        end else if (CALL) begin
            din_s       = TGT;
            ld_s        = 1'b1;
            push_req_s  = 1'b1;
            push_data_s = PC_COUNT + ADDR_W'(1);
        end else if (BR) begin
            din_s = TGT;
            ld_s  = 1'b1;
        end else if (ADV) begin
            inc_s = 1'b1;
        end else begin
            inc_s = 1'b0;
        end
    end

    // Interrupt enable and ISR state; RETI re-enables even against a same-cycle CLI.
    always_comb begin
        state_nxt_s = state_r;
        ie_nxt_s    = ie_r;
        if (intr_take_s) begin
            state_nxt_s = ISR;
        end else if (reti_isr_s) begin
            state_nxt_s = RUN;
        end else begin
            state_nxt_s = state_r;
        end
        if (reti_isr_s) begin
            ie_nxt_s = 1'b1;
        end else if (intr_take_s) begin
            ie_nxt_s = 1'b0;
        end else if (CLI) begin
            ie_nxt_s = 1'b0;
        end else if (SEI) begin
            ie_nxt_s = 1'b1;
        end else begin
            ie_nxt_s = ie_r;
        end
    end

    // State, enable and sticky error flags.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= RUN;
            ie_r    <= 1'b0;
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ie_r    <= ie_nxt_s;
            ovf_r   <= ovf_r | (push_req_s & full_s);
            unf_r   <= unf_r | (pop_req_s & empty_s);
        end
    end

    ras_lifo #(
        .DEPTH (DEPTH),
        .W     (ADDR_W)
    ) u_ras (
        .clk   (CLK),
        .rst   (RST),
        .push  (push_req_s),
        .pop   (pop_req_s),
        .din   (push_data_s),
        .top   (top_s),
        .full  (full_s),
        .empty (empty_s)
    );

    assign DIN    = RST ? '0 : din_s;
    assign PC_LD  = RST ? 1'b0 : ld_s;
    assign PC_INC = RST ? 1'b0 : inc_s;
    assign IN_ISR = (state_r == ISR);
    assign IE     = ie_r;
    assign OVF    = ovf_r;
    assign UNF    = unf_r;

endmodule

// File: tb/tb_pc_src_ctrl.sv
// Directed self-checking bench for pc_src_ctrl; honours PC_SRC_INTR_LATCH_EN for the latch scenario.
module tb_pc_src_ctrl;

    logic       clk;
    logic       rst;
    logic [9:0] pc_count;
    logic       adv, br, call, ret, reti, sei, cli, intr;
    logic [9:0] tgt;
    logic [9:0] din;
    logic       pc_ld, pc_inc, in_isr, ie, ovf, unf;

    int n_chk;
    int n_fail;

    pc_src_ctrl dut (
        .CLK      (clk),
        .RST      (rst),
        .PC_COUNT (pc_count),
        .ADV      (adv),
        .BR       (br),
        .CALL     (call),
        .RET      (ret),
        .RETI     (reti),
        .SEI      (sei),
        .CLI      (cli),
        .TGT      (tgt),
        .INTR     (intr),
        .DIN      (din),
        .PC_LD    (pc_ld),
        .PC_INC   (pc_inc),
        .IN_ISR   (in_isr),
        .IE       (ie),
        .OVF      (ovf),
        .UNF      (unf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic clear_inputs();
        adv = 1'b0; br = 1'b0; call = 1'b0; ret = 1'b0; reti = 1'b0;
        sei = 1'b0; cli = 1'b0; intr = 1'b0; tgt = 10'h000; pc_count = 10'h000;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        adv = 1'b1; call = 1'b1; intr = 1'b1; tgt = 10'h3FF; pc_count = 10'h005;
        tick();
        n_chk++; if (din !== 10'h000) begin n_fail++; $display("FAIL rst_din: got %h want %h", din, 10'h000); end
        n_chk++; if (pc_ld !== 1'b0 || pc_inc !== 1'b0) begin n_fail++; $display("FAIL rst_strobes: ld=%b inc=%b want 0 0", pc_ld, pc_inc); end
        n_chk++; if ({in_isr, ie, ovf, unf} !== 4'b0000) begin n_fail++; $display("FAIL rst_state: got %b want 0000", {in_isr, ie, ovf, unf}); end
        rst = 1'b0;
        clear_inputs();
        adv = 1'b1; pc_count = 10'h005;
        #1;
        n_chk++; if (pc_inc !== 1'b1 || pc_ld !== 1'b0 || din !== 10'h000) begin n_fail++; $display("FAIL adv: inc=%b ld=%b din=%h want 1 0 000", pc_inc, pc_ld, din); end
        tick();
    endtask

    task automatic test_call_ret();
        do_reset();
        call = 1'b1; tgt = 10'h120; pc_count = 10'h3FF;
        #1;
        n_chk++; if (din !== 10'h120 || pc_ld !== 1'b1 || pc_inc !== 1'b0) begin n_fail++; $display("FAIL call: din=%h ld=%b inc=%b want 120 1 0", din, pc_ld, pc_inc); end
        tick();
        clear_inputs();
        ret = 1'b1; pc_count = 10'h120;
        #1;
        n_chk++; if (din !== 10'h000 || pc_ld !== 1'b1) begin n_fail++; $display("FAIL ret_wrap: din=%h ld=%b want 000 1", din, pc_ld); end
        tick();
        n_chk++; if (ovf !== 1'b0 || unf !== 1'b0) begin n_fail++; $display("FAIL call_ret_flags: ovf=%b unf=%b want 0 0", ovf, unf); end
        // Stack must now be empty: a further RET underflows.
        #1;
        n_chk++; if (din !== 10'h000 || pc_ld !== 1'b1) begin n_fail++; $display("FAIL ret_empty: din=%h ld=%b want 000 1", din, pc_ld); end
        tick();
        n_chk++; if (unf !== 1'b1) begin n_fail++; $display("FAIL ret_empty_unf: got %b want 1", unf); end
        clear_inputs();
    endtask

    task automatic test_intr();
        do_reset();
        sei = 1'b1;
        tick();
        sei = 1'b0;
        n_chk++; if (ie !== 1'b1) begin n_fail++; $display("FAIL sei: ie=%b want 1", ie); end
        intr = 1'b1; pc_count = 10'h040; adv = 1'b1;
        #1;
        n_chk++; if (din !== 10'h3FF || pc_ld !== 1'b1 || pc_inc !== 1'b0) begin n_fail++; $display("FAIL intr_take: din=%h ld=%b inc=%b want 3ff 1 0", din, pc_ld, pc_inc); end
        tick();
        adv = 1'b0;
        n_chk++; if (in_isr !== 1'b1 || ie !== 1'b0) begin n_fail++; $display("FAIL intr_state: isr=%b ie=%b want 1 0", in_isr, ie); end
        pc_count = 10'h3FF;
        #1;
        n_chk++; if (pc_ld !== 1'b0 || din !== 10'h000) begin n_fail++; $display("FAIL intr_in_isr: ld=%b din=%h want 0 000", pc_ld, din); end
        tick();
        intr = 1'b0; reti = 1'b1; cli = 1'b1;
        #1;
        n_chk++; if (din !== 10'h040 || pc_ld !== 1'b1) begin n_fail++; $display("FAIL reti: din=%h ld=%b want 040 1", din, pc_ld); end
        tick();
        clear_inputs();
        n_chk++; if (in_isr !== 1'b0 || ie !== 1'b1) begin n_fail++; $display("FAIL reti_state: isr=%b ie=%b want 0 1", in_isr, ie); end
        sei = 1'b1; cli = 1'b1;
        tick();
        clear_inputs();
        n_chk++; if (ie !== 1'b0) begin n_fail++; $display("FAIL sei_cli: ie=%b want 0", ie); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            call = 1'b1; tgt = 10'h010; pc_count = 10'(i * 17);
            #1;
            n_chk++; if (din !== 10'h010 || pc_ld !== 1'b1) begin n_fail++; $display("FAIL ovf_call%0d: din=%h ld=%b want 010 1", i, din, pc_ld); end
            tick();
            n_chk++; if (ovf !== (i == 8)) begin n_fail++; $display("FAIL ovf_flag%0d: got %b want %b", i, ovf, (i == 8)); end
        end
        clear_inputs();
        for (int k = 0; k < 8; k++) begin
            ret = 1'b1;
            #1;
            n_chk++; if (din !== 10'((7 - k) * 17 + 1) || pc_ld !== 1'b1) begin n_fail++; $display("FAIL lifo_ret%0d: din=%h want %h", k, din, 10'((7 - k) * 17 + 1)); end
            tick();
        end
        n_chk++; if (unf !== 1'b0) begin n_fail++; $display("FAIL unf_early: got %b want 0", unf); end
        #1;
        n_chk++; if (din !== 10'h000 || pc_ld !== 1'b1) begin n_fail++; $display("FAIL ret9: din=%h ld=%b want 000 1", din, pc_ld); end
        tick();
        clear_inputs();
        n_chk++; if (unf !== 1'b1 || ovf !== 1'b1) begin n_fail++; $display("FAIL sticky: unf=%b ovf=%b want 1 1", unf, ovf); end
    endtask

    task automatic test_priority();
        do_reset();
        call = 1'b1; br = 1'b1; adv = 1'b1; tgt = 10'h2AA; pc_count = 10'h100;
        #1;
        n_chk++; if (din !== 10'h2AA || pc_ld !== 1'b1 || pc_inc !== 1'b0) begin n_fail++; $display("FAIL prio_call: din=%h ld=%b inc=%b want 2aa 1 0", din, pc_ld, pc_inc); end
        tick();
        clear_inputs();
        br = 1'b1; adv = 1'b1; tgt = 10'h155;
        #1;
        n_chk++; if (din !== 10'h155 || pc_ld !== 1'b1 || pc_inc !== 1'b0) begin n_fail++; $display("FAIL prio_br: din=%h ld=%b inc=%b want 155 1 0", din, pc_ld, pc_inc); end
        tick();
        clear_inputs();
        ret = 1'b1; call = 1'b1; tgt = 10'h077;
        #1;
        n_chk++; if (din !== 10'h101 || pc_ld !== 1'b1) begin n_fail++; $display("FAIL prio_ret: din=%h ld=%b want 101 1", din, pc_ld); end
        tick();
        clear_inputs();
        ret = 1'b1;
        #1;
        n_chk++; if (din !== 10'h000) begin n_fail++; $display("FAIL one_push: din=%h want 000", din); end
        tick();
        clear_inputs();
        n_chk++; if (unf !== 1'b1 || ovf !== 1'b0) begin n_fail++; $display("FAIL prio_flags: unf=%b ovf=%b want 1 0", unf, ovf); end
    endtask

    task automatic test_intr_latch();
        logic exp_take;
`ifdef PC_SRC_INTR_LATCH_EN
        exp_take = 1'b1;
`else
        exp_take = 1'b0;
`endif
        do_reset();
        intr = 1'b1; pc_count = 10'h033;
        #1;
        n_chk++; if (pc_ld !== 1'b0) begin n_fail++; $display("FAIL masked_intr: ld=%b want 0", pc_ld); end
        tick();
        intr = 1'b0; sei = 1'b1;
        #1;
        n_chk++; if (pc_ld !== 1'b0) begin n_fail++; $display("FAIL sei_cycle: ld=%b want 0", pc_ld); end
        tick();
        sei = 1'b0;
        #1;
        n_chk++; if (pc_ld !== exp_take || din !== (exp_take ? 10'h3FF : 10'h000)) begin n_fail++; $display("FAIL latch_take: ld=%b din=%h want %b", pc_ld, din, exp_take); end
        tick();
        n_chk++; if (in_isr !== exp_take) begin n_fail++; $display("FAIL latch_isr: got %b want %b", in_isr, exp_take); end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        sei = 1'b1;
        tick();
        sei = 1'b0; intr = 1'b1; pc_count = 10'h050;
        tick();
        intr = 1'b0; ret = 1'b1;
        #1;
        n_chk++; if (din !== 10'h050 || in_isr !== 1'b1) begin n_fail++; $display("FAIL mid_pre: din=%h isr=%b want 050 1", din, in_isr); end
        #1 rst = 1'b1;
        #1;
        n_chk++; if (din !== 10'h000 || pc_ld !== 1'b0 || in_isr !== 1'b0 || ie !== 1'b0) begin n_fail++; $display("FAIL mid_rst: din=%h ld=%b isr=%b ie=%b want 000 0 0 0", din, pc_ld, in_isr, ie); end
        #1 rst = 1'b0;
        #1;
        n_chk++; if (din !== 10'h000 || pc_ld !== 1'b1) begin n_fail++; $display("FAIL mid_sp: din=%h ld=%b want 000 1", din, pc_ld); end
        tick();
        clear_inputs();
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        clear_inputs();
        test_reset();
        test_call_ret();
        test_intr();
        test_overflow();
        test_priority();
        test_intr_latch();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
